// File: rtl/bcd2bin_seq.sv
// -----------------------------------------------------------------------------
// bcd2bin_seq
//   Sequential signed BCD-to-binary converter (inverse of the display-side
//   bin2bcd). A sign nibble plus `digits` BCD digits are converted to a
//   `width`-bit two's-complement operand by reverse double-dabble, one bit per
//   clock, under a start/busy/done handshake.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   rst_n    : synchronous reset, active-low
//   start    : conversion request, sampled only while idle
//   bcd      : BCD magnitude, digit 0 (units) in [3:0]
//   bcd_sgn  : sign nibble, 4'hA = negative, anything else = positive
//   bin      : two's-complement result, held until the next done
//   busy     : high while a conversion is in progress
//   done     : one-cycle pulse when bin/err are valid
//   err      : valid with done; invalid digit or result out of range
// -----------------------------------------------------------------------------
module bcd2bin_seq #(
  parameter int width  = 6,
  parameter int digits = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*digits-1:0]   bcd,
  input  logic [3:0]            bcd_sgn,
  output logic [width-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int ACC_W = 4 * digits;
  localparam int CNT_W = $clog2(ACC_W + 1);

  // Largest magnitudes representable for each sign in `width` bits.
  localparam logic [31:0] LIM_POS = 32'((64'd1 << (width - 1)) - 64'd1);
  localparam logic [31:0] LIM_NEG = 32'(64'd1 << (width - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [ACC_W-1:0]   bcd_r;
  logic [ACC_W-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r;
  logic               bad_r;

  logic [2*ACC_W-1:0] step_s;
  logic               range_err_s;
  logic [width-1:0]   fin_bin_s;

  // One reverse double-dabble step: shift the combined register right, then
  // pull every BCD nibble that landed at >= 8 back into decimal range.
  function automatic logic [2*ACC_W-1:0] dabble_step(input logic [2*ACC_W-1:0] v);
    logic [2*ACC_W-1:0] s;
    s = v >> 1;
    for (int i = 0; i < digits; i++) begin
      if (s[ACC_W + 4*i +: 4] >= 4'd8) begin
        s[ACC_W + 4*i +: 4] = s[ACC_W + 4*i +: 4] - 4'd3;
      end else begin
        s[ACC_W + 4*i +: 4] = s[ACC_W + 4*i +: 4];
      end
    end
    return s;
  endfunction

  // Flags any nibble outside 0..9.
  function automatic logic any_bad_digit(input logic [ACC_W-1:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < digits; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // Next shift-register value and final-result evaluation from the magnitude.
  always_comb begin
    step_s      = dabble_step({bcd_r, acc_r});
    range_err_s = 1'b0;
    fin_bin_s   = '0;
    if (neg_r) begin
      range_err_s = (32'(acc_r) > LIM_NEG);
      fin_bin_s   = width'(0) - width'(acc_r);
    end else begin
      range_err_s = (32'(acc_r) > LIM_POS);
      fin_bin_s   = width'(acc_r);
    end
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      bcd_r   <= '0;
      acc_r   <= '0;
      cnt_r   <= '0;
      neg_r   <= 1'b0;
      bad_r   <= 1'b0;
      bin     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bcd_r   <= bcd;
            acc_r   <= '0;
            cnt_r   <= '0;
            neg_r   <= (bcd_sgn == 4'hA);
            bad_r   <= any_bad_digit(bcd);
            busy    <= 1'b1;
            state_r <= CONV;
          end else begin
            busy <= 1'b0;
          end
        end
        CONV: begin
          done  <= 1'b0;
          busy  <= 1'b1;
          bcd_r <= step_s[2*ACC_W-1:ACC_W];
          acc_r <= step_s[ACC_W-1:0];
          if (cnt_r == CNT_W'(ACC_W - 1)) begin
            state_r <= FIN;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        FIN: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= IDLE;
          // -0 passes the negative range check and negates to 0.
          if (bad_r || range_err_s) begin
            err <= 1'b1;
            bin <= '0;
          end else begin
            err <= 1'b0;
            bin <= fin_bin_s;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst_n;

  logic        start6;
  logic [7:0]  bcd6;
  logic [3:0]  sgn6;
  logic [5:0]  bin6;
  logic        busy6, done6, err6;

  logic        start12;
  logic [15:0] bcd12;
  logic [3:0]  sgn12;
  logic [11:0] bin12;
  logic        busy12, done12, err12;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bcd2bin_seq #(.width(6), .digits(2)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .bcd(bcd6), .bcd_sgn(sgn6),
    .bin(bin6), .busy(busy6), .done(done6), .err(err6)
  );

  bcd2bin_seq #(.width(12), .digits(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start12), .bcd(bcd12), .bcd_sgn(sgn12),
    .bin(bin12), .busy(busy12), .done(done12), .err(err12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: decimal value from digits, range rule, two's complement.
  function automatic void model(input int w, input int nd, input logic [15:0] b,
                                input logic [3:0] s, output logic [31:0] eb,
                                output logic ee);
    int mag, lim, d;
    logic bad, neg;
    mag = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      mag = mag * 10 + d;
    end
    neg = (s == 4'hA);
    lim = neg ? (1 << (w - 1)) : ((1 << (w - 1)) - 1);
    ee  = bad || (mag > lim);
    if (ee) eb = 32'd0;
    else    eb = neg ? 32'(-mag) : 32'(mag);
    eb = eb & ((32'd1 << w) - 32'd1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start6 = 1'b0; start12 = 1'b0;
    bcd6 = 8'h00; sgn6 = 4'h0; bcd12 = 16'h0000; sgn12 = 4'h0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bin6, busy6, done6, err6} !== 9'd0) $display("FAIL reset6: got %b expected 0", {bin6, busy6, done6, err6});
    else pass_cnt++;
    total_cnt++;
    if ({bin12, busy12, done12, err12} !== 15'd0) $display("FAIL reset12: got %b expected 0", {bin12, busy12, done12, err12});
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Full 6-bit conversion with latency, handshake and hold checks.
  task automatic conv6(input logic [7:0] b, input logic [3:0] s, input string name);
    logic [31:0] eb; logic ee;
    model(6, 2, {8'h00, b}, s, eb, ee);
    bcd6 = b; sgn6 = s; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      total_cnt++;
      if (busy6 !== 1'b1 || done6 !== 1'b0) $display("FAIL %s busy cyc%0d: got busy=%b done=%b expected busy=1 done=0", name, i, busy6, done6);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (done6 !== 1'b1 || busy6 !== 1'b0) $display("FAIL %s done: got done=%b busy=%b expected done=1 busy=0", name, done6, busy6);
    else pass_cnt++;
    total_cnt++;
    if (bin6 !== eb[5:0] || err6 !== ee) $display("FAIL %s result: got bin=%h err=%b expected bin=%h err=%b", name, bin6, err6, eb[5:0], ee);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (done6 !== 1'b0 || bin6 !== eb[5:0] || err6 !== ee) $display("FAIL %s hold: got done=%b bin=%h err=%b expected done=0 bin=%h err=%b", name, done6, bin6, err6, eb[5:0], ee);
    else pass_cnt++;
  endtask

  task automatic conv12(input logic [15:0] b, input logic [3:0] s, input string name);
    logic [31:0] eb; logic ee;
    model(12, 4, b, s, eb, ee);
    bcd12 = b; sgn12 = s; start12 = 1'b1;
    @(negedge clk);
    start12 = 1'b0;
    for (int i = 0; i < 17; i++) begin
      total_cnt++;
      if (busy12 !== 1'b1 || done12 !== 1'b0) $display("FAIL %s busy cyc%0d: got busy=%b done=%b expected busy=1 done=0", name, i, busy12, done12);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (done12 !== 1'b1 || busy12 !== 1'b0 || bin12 !== eb[11:0] || err12 !== ee)
      $display("FAIL %s done: got done=%b busy=%b bin=%h err=%b expected done=1 busy=0 bin=%h err=%b", name, done12, busy12, bin12, err12, eb[11:0], ee);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_directed();
    conv6(8'h31, 4'hF, "pos31");
    conv6(8'h32, 4'hA, "neg32");
    conv6(8'h32, 4'hF, "pos32_range");
    conv6(8'h1C, 4'hF, "bad_digit");
    conv6(8'h99, 4'hF, "pos99_range");
    conv6(8'h00, 4'hA, "neg_zero");
    conv6(8'h07, 4'hA, "neg7");
  endtask

  task automatic test_random();
    logic [7:0] b; logic [3:0] s;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) != 0) b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else                           b = 8'($urandom);
      s = ($urandom_range(0, 1) == 1) ? 4'hA : 4'($urandom_range(0, 15));
      conv6(b, s, "random");
    end
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int done_at = -1;
    bcd6 = 8'h25; sgn6 = 4'hA; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin bcd6 = 8'h11; sgn6 = 4'hF; start6 = 1'b1; end
      else start6 = 1'b0;
      @(negedge clk);
      if (done6 === 1'b1) begin dones++; done_at = c; end
    end
    total_cnt++;
    if (dones != 1 || done_at != 9) $display("FAIL ignore_start: got dones=%0d at=%0d expected 1 at 9", dones, done_at);
    else pass_cnt++;
    total_cnt++;
    if (bin6 !== 6'b100111 || err6 !== 1'b0) $display("FAIL ignore_start result: got bin=%b err=%b expected 100111 0", bin6, err6);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    conv6(8'h31, 4'hF, "pre_reset");
    bcd6 = 8'h12; sgn6 = 4'hF; start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total_cnt++;
    if ({bin6, busy6, done6, err6} !== 9'd0) $display("FAIL reset_mid: got %b expected 0", {bin6, busy6, done6, err6});
    else pass_cnt++;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done6 === 1'b1 || busy6 === 1'b1) dones++;
    end
    total_cnt++;
    if (dones != 0) $display("FAIL reset_mid_nodone: got %0d done/busy cycles expected 0", dones);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bcd6 = 8'h14; sgn6 = 4'hF; start6 = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    total_cnt++;
    if (done6 !== 1'b1 || bin6 !== 6'd14) $display("FAIL b2b first: got done=%b bin=%0d expected 1 14", done6, bin6);
    else pass_cnt++;
    bcd6 = 8'h09; sgn6 = 4'hA;
    @(negedge clk);
    start6 = 1'b0;
    total_cnt++;
    if (busy6 !== 1'b1 || done6 !== 1'b0) $display("FAIL b2b relaunch: got busy=%b done=%b expected 1 0", busy6, done6);
    else pass_cnt++;
    repeat (9) @(negedge clk);
    total_cnt++;
    if (done6 !== 1'b1 || bin6 !== 6'b110111 || err6 !== 1'b0) $display("FAIL b2b second: got done=%b bin=%b err=%b expected 1 110111 0", done6, bin6, err6);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_wide();
    conv12(16'h2047, 4'hF, "w_pos2047");
    conv12(16'h2048, 4'hA, "w_neg2048");
    conv12(16'h2048, 4'hF, "w_pos2048_range");
    for (int n = 0; n < 6; n++)
      conv12({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
             ($urandom_range(0, 1) == 1) ? 4'hA : 4'h0, "w_random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
